// File: rtl/pwm_adc_scan_ctrl.sv
// Scan controller sharing one ramp ADC across NCH LVDS comparator channels.
// Each enabled channel gets a settle window, a bounded conversion and a handshaked result.
module pwm_adc_scan_ctrl #(
  parameter int NBITS       = 8,
  parameter int NCH         = 4,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1024,
  localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             continuous_i,
  input  logic [NCH-1:0]   ch_mask_i,
  output logic             adc_enable_o,
  output logic [CHW-1:0]   adc_ch_sel_o,
  input  logic [NBITS-1:0] adc_value_i,
  input  logic             adc_valid_i,
  output logic [NBITS-1:0] result_o,
  output logic [CHW-1:0]   result_ch_o,
  output logic             result_err_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  // state    | meaning
  // S_IDLE   | waiting for start_i
  // S_SETTLE | mux switched, ADC disabled, settle timer running
  // S_CONVERT| ADC enabled, waiting for adc_valid_i or timeout
  // S_OUTPUT | result presented until result_ready_i
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CONVERT = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LOAD  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYC - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [NCH-1:0]   scan_mask, scan_mask_nxt;
  logic [CHW-1:0]   ch_sel, ch_sel_nxt;
  logic [NBITS-1:0] result, result_nxt;
  logic [CHW-1:0]   result_ch, result_ch_nxt;
  logic             result_err, result_err_nxt;
  logic             done_q, done_nxt;
  logic             done_xfer;

  function automatic logic [CHW-1:0] lowest_bit(input logic [NCH-1:0] m);
    logic [CHW-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) idx = CHW'(i);
    end
    return idx;
  endfunction

  function automatic logic has_above(input logic [NCH-1:0] m, input logic [CHW-1:0] cur);
    logic found;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (m[i] && (i > int'(cur))) found = 1'b1;
    end
    return found;
  endfunction

  function automatic logic [CHW-1:0] next_above(input logic [NCH-1:0] m,
                                                input logic [CHW-1:0] cur);
    logic [CHW-1:0] idx;
    idx = cur;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) idx = CHW'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      scan_mask  <= '0;
      ch_sel     <= '0;
      result     <= '0;
      result_ch  <= '0;
      result_err <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      scan_mask  <= scan_mask_nxt;
      ch_sel     <= ch_sel_nxt;
      result     <= result_nxt;
      result_ch  <= result_ch_nxt;
      result_err <= result_err_nxt;
      done_q     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    scan_mask_nxt  = scan_mask;
    ch_sel_nxt     = ch_sel;
    result_nxt     = result;
    result_ch_nxt  = result_ch;
    result_err_nxt = result_err;
    done_nxt       = 1'b0;
    done_xfer      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start_i) begin
          scan_mask_nxt = ch_mask_i;
          if (|ch_mask_i) begin
            state_nxt  = S_SETTLE;
            ch_sel_nxt = lowest_bit(ch_mask_i);
            cnt_nxt    = SETTLE_LOAD;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end

      S_SETTLE: begin
        if (cnt == '0) begin
          state_nxt = S_CONVERT;
          cnt_nxt   = TIMEOUT_LOAD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end

      S_CONVERT: begin
        // A strobe on the final timeout cycle still counts as a real result.
        if (adc_valid_i) begin
          state_nxt      = S_OUTPUT;
          result_nxt     = adc_value_i;
          result_ch_nxt  = ch_sel;
          result_err_nxt = 1'b0;
          cnt_nxt        = '0;
        end else if (cnt == '0) begin
          state_nxt      = S_OUTPUT;
          result_nxt     = '1;
          result_ch_nxt  = ch_sel;
          result_err_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end

      S_OUTPUT: begin
        if (result_ready_i) begin
          if (has_above(scan_mask, ch_sel)) begin
            state_nxt  = S_SETTLE;
            ch_sel_nxt = next_above(scan_mask, ch_sel);
            cnt_nxt    = SETTLE_LOAD;
          end else begin
            done_xfer = 1'b1;
            if (continuous_i) begin
              scan_mask_nxt = ch_mask_i;
              if (|ch_mask_i) begin
                state_nxt  = S_SETTLE;
                ch_sel_nxt = lowest_bit(ch_mask_i);
                cnt_nxt    = SETTLE_LOAD;
              end else begin
                state_nxt = S_IDLE;
              end
            end else begin
              state_nxt = S_IDLE;
            end
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign adc_enable_o   = (state == S_CONVERT);
  assign adc_ch_sel_o   = ch_sel;
  assign result_o       = result;
  assign result_ch_o    = result_ch;
  assign result_err_o   = result_err;
  assign result_valid_o = (state == S_OUTPUT);
  assign busy_o         = (state != S_IDLE);
  // End-of-pass done coincides with the final transfer; an empty-mask start uses the registered pulse.
  assign done_o         = done_q | done_xfer;

endmodule
